// File: rtl/ctrl_pkg.sv
// ctrl_pkg: decoder states, instruction field positions, op-form constants, ALU codes and the register-select helper
package ctrl_pkg;
  typedef enum logic [1:0] {FETCH, EXT_WAIT, EXEC} state_t;
  typedef enum logic [1:0] {FORM_REG, FORM_SHORT, FORM_LONG, FORM_ILL} form_t;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 8;
  localparam int EXT_HI = 7;
  localparam int EXT_LO = 4;
  localparam int RS_HI = 3;
  localparam int RS_LO = 0;
  localparam int IMM_HI = 7;
  localparam logic [3:0] OP_REG = 4'h0;
  localparam logic [3:0] OP_LONG = 4'hE;
  localparam logic [3:0] OP_ILL = 4'hF;
  localparam logic [7:0] ALU_ADD = 8'h05;
  localparam logic [7:0] ALU_SUB = 8'h09;
  localparam logic [7:0] ALU_CMP = 8'h0B;
  function automatic logic [4:0] reg_sel(input logic [3:0] r);
    return {1'b0, r} + 5'd1;
  endfunction
endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational word decode; in word, out opcode/sel_a/sel_b/imm/imm_sel/rd/ext/form
import ctrl_pkg::*;
module instr_field_decode #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] word,
  output logic [7:0]        opcode,
  output logic [4:0]        sel_a,
  output logic [4:0]        sel_b,
  output logic [DATA_W-1:0] imm,
  output logic              imm_sel,
  output logic [3:0]        rd,
  output logic [3:0]        ext,
  output form_t             form
);
  logic [3:0] op;
  logic [3:0] rs;
  always_comb begin
    op = word[OP_HI:OP_LO];
    rd = word[RD_HI:RD_LO];
    ext = word[EXT_HI:EXT_LO];
    rs = word[RS_HI:RS_LO];
    form = op == OP_REG ? FORM_REG : op == OP_LONG ? FORM_LONG : op == OP_ILL ? FORM_ILL : FORM_SHORT;
    opcode = form == FORM_REG ? {op, ext} : {4'b0000, form == FORM_LONG ? ext : op};
    sel_a = reg_sel(rd);
    sel_b = form == FORM_REG ? reg_sel(rs) : 5'd0;
    imm_sel = form == FORM_SHORT;
    imm = imm_sel ? {{(DATA_W-8){word[IMM_HI]}}, word[IMM_HI:0]} : '0;
  end
endmodule

// File: rtl/instr_decoder.sv
// instr_decoder: FETCH/EXT_WAIT/EXEC decoder; in clk/reset(n)/instr/instr_valid, out instr_ready/immediate/enable/control1/control2/imm_control/opcode/buff_en/illegal, all registered
import ctrl_pkg::*;
module instr_decoder #(
  parameter int DATA_W = 16,
  parameter int NREG = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] immediate,
  output logic [NREG-1:0]   enable,
  output logic [4:0]        control1,
  output logic [4:0]        control2,
  output logic              imm_control,
  output logic [7:0]        opcode,
  output logic              buff_en,
  output logic              illegal
);
  state_t state, state_n;
  form_t fd_form;
  logic [7:0] fd_opcode, opc_n;
  logic [4:0] fd_sel_a, fd_sel_b, c1_n, c2_n;
  logic [DATA_W-1:0] fd_imm, imm_n;
  logic fd_imm_sel, immc_n, ill_n, go, accept;
  logic [3:0] fd_rd, fd_ext, rd_n, rd_q, ext_q;
  instr_field_decode #(.DATA_W(DATA_W)) u_fd (
    .word(instr),
    .opcode(fd_opcode),
    .sel_a(fd_sel_a),
    .sel_b(fd_sel_b),
    .imm(fd_imm),
    .imm_sel(fd_imm_sel),
    .rd(fd_rd),
    .ext(fd_ext),
    .form(fd_form)
  );
  assign accept = instr_valid && instr_ready;
  // EXT_WAIT replays the latched rd/ext and takes the whole word as the immediate
  always_comb begin
    state_n = state;
    ill_n = 1'b0;
    opc_n = fd_opcode;
    c1_n = fd_sel_a;
    c2_n = fd_sel_b;
    imm_n = fd_imm;
    immc_n = fd_imm_sel;
    rd_n = fd_rd;
    unique case (state)
      FETCH: if (accept) begin
        ill_n = fd_form == FORM_ILL;
        state_n = fd_form == FORM_LONG ? EXT_WAIT : fd_form == FORM_ILL ? FETCH : EXEC;
      end
      EXT_WAIT: if (accept) begin
        state_n = EXEC;
        opc_n = {4'b0000, ext_q};
        c1_n = reg_sel(rd_q);
        c2_n = 5'd0;
        imm_n = instr;
        immc_n = 1'b1;
        rd_n = rd_q;
      end
      default: state_n = FETCH;
    endcase
    go = state_n == EXEC;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      instr_ready <= 1'b0;
      illegal <= 1'b0;
      opcode <= '0;
      control1 <= '0;
      control2 <= '0;
      immediate <= '0;
      imm_control <= 1'b0;
      enable <= '0;
      buff_en <= 1'b0;
      rd_q <= '0;
      ext_q <= '0;
    end else begin
      state <= state_n;
      instr_ready <= state_n != EXEC;
      illegal <= ill_n;
      opcode <= go ? opc_n : '0;
      control1 <= go ? c1_n : '0;
      control2 <= go ? c2_n : '0;
      immediate <= go ? imm_n : '0;
      imm_control <= go && immc_n;
      enable <= go && opc_n != ALU_CMP ? NREG'(1) << rd_n : '0;
      buff_en <= go;
      if (state == FETCH && accept && fd_form == FORM_LONG) begin
        rd_q <= fd_rd;
        ext_q <= fd_ext;
      end
    end
  end
endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: directed vectors, per-cycle behavioural model compare plus literal spot checks
module tb_instr_decoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] instr = '0;
  logic instr_valid = 1'b0;
  logic instr_ready, imm_control, buff_en, illegal;
  logic [15:0] immediate, enable;
  logic [4:0] control1, control2;
  logic [7:0] opcode;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  instr_decoder dut (
    .clk(clk),
    .reset(reset),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .immediate(immediate),
    .enable(enable),
    .control1(control1),
    .control2(control2),
    .imm_control(imm_control),
    .opcode(opcode),
    .buff_en(buff_en),
    .illegal(illegal)
  );
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    end
  endtask
  logic [15:0] e_imm, e_en;
  logic [4:0] e_c1, e_c2;
  logic [7:0] e_op;
  logic e_immc, e_buf, e_ill;
  logic e_rdy = 1'b0;
  bit pend, exec;
  int op, rd, ext, rs, imm8, erd, prd, pext;
  // Model: what each cycle's outputs must be, from the word accepted at the previous edge
  always @(posedge clk) begin
    {e_imm, e_en, e_c1, e_c2, e_op, e_immc, e_buf, e_ill} = '0;
    exec = 0;
    if (!reset) begin
      e_rdy = 0;
      pend = 0;
    end else begin
      op = int'(instr) / 4096;
      rd = (int'(instr) / 256) % 16;
      ext = (int'(instr) / 16) % 16;
      rs = int'(instr) % 16;
      imm8 = int'(instr) % 256;
      erd = rd;
      if (instr_valid && e_rdy) begin
        if (pend) begin
          exec = 1; erd = prd; e_op = 8'(pext); e_imm = instr; e_immc = 1; pend = 0;
        end else if (op == 0) begin
          exec = 1; e_op = 8'(op * 16 + ext); e_c2 = 5'(rs + 1);
        end else if (op == 15) begin
          e_ill = 1;
        end else if (op == 14) begin
          pend = 1; prd = rd; pext = ext;
        end else begin
          exec = 1; e_op = 8'(op); e_immc = 1;
          e_imm = imm8 >= 128 ? 16'(imm8 + 'hFF00) : 16'(imm8);
        end
      end
      if (exec) begin
        e_c1 = 5'(erd + 1);
        e_buf = 1;
        e_en = e_op == 8'h0B ? 16'h0 : 16'(1 << erd);
      end
      e_rdy = !exec;
    end
    #1;
    chk("m_ready", 32'(instr_ready), 32'(e_rdy));
    chk("m_illegal", 32'(illegal), 32'(e_ill));
    chk("m_opcode", 32'(opcode), 32'(e_op));
    chk("m_enable", 32'(enable), 32'(e_en));
    chk("m_control1", 32'(control1), 32'(e_c1));
    chk("m_control2", 32'(control2), 32'(e_c2));
    chk("m_immediate", 32'(immediate), 32'(e_imm));
    chk("m_imm_control", 32'(imm_control), 32'(e_immc));
    chk("m_buff_en", 32'(buff_en), 32'(e_buf));
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      instr_valid = 0;
    end
  endtask
  // Presents w for one accepting edge and returns in the following (EXEC) cycle
  task automatic send(input logic [15:0] w);
    @(negedge clk);
    instr = w;
    instr_valid = 1;
    @(negedge clk);
    instr_valid = 0;
  endtask
  logic [15:0] burst [8] = '{16'h2A7F, 16'h0123, 16'hE7A0, 16'h8001, 16'hF0F0, 16'h3C80, 16'h0FB0, 16'hD5FF};
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 0);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_buff", 32'(buff_en), 0);
    reset = 1;
    @(negedge clk);
    chk("first_ready", 32'(instr_ready), 1);
    send(16'h0596);
    chk("reg0596_op", 32'(opcode), 32'h09);
    chk("reg0596_en", 32'(enable), 32'h0020);
    chk("reg0596_c1", 32'(control1), 6);
    chk("reg0596_c2", 32'(control2), 7);
    chk("reg0596_immc", 32'(imm_control), 0);
    chk("exec_ready", 32'(instr_ready), 0);
    idle(1);
    send(16'h5596);
    chk("short_op", 32'(opcode), 32'h05);
    chk("short_imm", 32'(immediate), 32'hFF96);
    chk("short_en", 32'(enable), 32'h0020);
    chk("short_c1", 32'(control1), 6);
    chk("short_immc", 32'(imm_control), 1);
    chk("short_buff", 32'(buff_en), 1);
    idle(1);
    send(16'h0391);
    chk("sub_op", 32'(opcode), 32'h09);
    chk("sub_c1", 32'(control1), 4);
    chk("sub_c2", 32'(control2), 2);
    chk("sub_en", 32'(enable), 32'h0008);
    idle(1);
    send(16'hE250);
    chk("ext_ready", 32'(instr_ready), 1);
    chk("ext_op", 32'(opcode), 0);
    chk("ext_buff", 32'(buff_en), 0);
    idle(1);
    chk("ext_hold_ready", 32'(instr_ready), 1);
    chk("ext_hold_en", 32'(enable), 0);
    send(16'h1234);
    chk("long_op", 32'(opcode), 32'h05);
    chk("long_imm", 32'(immediate), 32'h1234);
    chk("long_en", 32'(enable), 32'h0004);
    chk("long_immc", 32'(imm_control), 1);
    idle(1);
    send(16'h04B7);
    chk("cmp_op", 32'(opcode), 32'h0B);
    chk("cmp_en", 32'(enable), 0);
    chk("cmp_buff", 32'(buff_en), 1);
    idle(1);
    send(16'hF000);
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_buff", 32'(buff_en), 0);
    chk("ill_ready", 32'(instr_ready), 1);
    idle(1);
    chk("ill_clear", 32'(illegal), 0);
    send(16'hE7A0);
    send(16'h8001);
    chk("long_neg_imm", 32'(immediate), 32'h8001);
    chk("long_neg_op", 32'(opcode), 32'h0A);
    chk("long_neg_en", 32'(enable), 32'h0080);
    idle(1);
    send(16'hE250);
    reset = 0;
    @(negedge clk);
    chk("midrst_ready", 32'(instr_ready), 0);
    chk("midrst_op", 32'(opcode), 0);
    reset = 1;
    @(negedge clk);
    send(16'h1234);
    chk("after_rst_op", 32'(opcode), 32'h01);
    chk("after_rst_imm", 32'(immediate), 32'h0034);
    chk("after_rst_en", 32'(enable), 32'h0004);
    idle(1);
    send(16'h0391);
    reset = 0;
    @(negedge clk);
    chk("exec_rst_en", 32'(enable), 0);
    reset = 1;
    idle(1);
    foreach (burst[i]) begin
      @(negedge clk);
      instr = burst[i];
      instr_valid = 1;
    end
    idle(4);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
